// File: rtl/dmr_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// dmr_pkg: shared size encodings, FSM states and wait-counter width.
// Rev 1.0
// ------------------------------------------------------------------
package dmr_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } dmr_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmr_state_e;

  localparam int WAIT_CNT_W = 4;

  function automatic logic [31:0] dmr_extend16(input logic [15:0] v, input logic sgn);
    return sgn ? {{16{v[15]}}, v} : {16'h0000, v};
  endfunction

  function automatic logic [31:0] dmr_extend8(input logic [7:0] v, input logic sgn);
    return sgn ? {{24{v[7]}}, v} : {24'h000000, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmr_lane_align.sv
`default_nettype none
// ------------------------------------------------------------------
// dmr_lane_align: little-endian store lane mask/replication and load
// lane extraction with sign/zero extension. Purely combinational.
// Rev 1.0
// ------------------------------------------------------------------
module dmr_lane_align
  import dmr_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  dmr_size_e   size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        bad_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign w_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    rdata_o = 32'h0;
    bad_o   = 1'b0;
    case (size_i)
      SIZE_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = dmr_extend8(w_byte, signed_i);
      end
      SIZE_HALF: begin
        bad_o   = addr_lo_i[0];
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = dmr_extend16(w_half, signed_i);
      end
      SIZE_WORD: begin
        bad_o   = (addr_lo_i != 2'b00);
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      default: begin
        bad_o = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ------------------------------------------------------------------
// data_mem_responder: single-outstanding data memory with fixed wait
// states. Define DMR_ERR_COUNT_EN to add the saturating ErrCount output.
// Rev 1.0
// ------------------------------------------------------------------
module data_mem_responder
  import dmr_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspRData,
  output logic        RspError
`ifdef DMR_ERR_COUNT_EN
  ,
  output logic [15:0] ErrCount
`endif
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
      (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  dmr_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  write_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  dmr_size_e             size_q;
  logic                  signed_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        w_idle;
  logic        w_hs;
  logic        w_enter_resp;
  logic        w_cur_write;
  logic [31:0] w_cur_addr;
  logic [31:0] w_cur_wdata;
  dmr_size_e   w_cur_size;
  logic        w_cur_signed;
  logic        w_in_range;
  logic        w_bad;
  logic        w_err;
  logic        w_mem_we;
  logic [IDX_W-1:0] w_idx;
  logic [31:0] w_rword;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_sh;
  logic [31:0] w_load;

  assign w_idle = (state_q == ST_IDLE);
  assign w_hs   = ReqValid && w_idle;

  // With zero wait states RESP is entered on the handshake edge itself,
  // so the access must see the live request rather than the latched copy.
  assign w_cur_write  = w_idle ? ReqWrite               : write_q;
  assign w_cur_addr   = w_idle ? ReqAddr                : addr_q;
  assign w_cur_wdata  = w_idle ? ReqWData               : wdata_q;
  assign w_cur_size   = w_idle ? dmr_size_e'(ReqSize)   : size_q;
  assign w_cur_signed = w_idle ? ReqSigned              : signed_q;

  assign w_in_range = ({2'b00, w_cur_addr[31:2]} < 32'(DEPTH_WORDS));
  assign w_err      = w_bad || !w_in_range;
  assign w_idx      = w_cur_addr[IDX_W+1:2];
  assign w_rword    = mem_q[w_idx];
  assign w_mem_we   = w_enter_resp && w_cur_write && !w_err;

  dmr_lane_align u_lane_align (
    .addr_lo_i (w_cur_addr[1:0]),
    .size_i    (w_cur_size),
    .signed_i  (w_cur_signed),
    .wdata_i   (w_cur_wdata),
    .rword_i   (w_rword),
    .be_o      (w_be),
    .wdata_o   (w_wdata_sh),
    .rdata_o   (w_load),
    .bad_o     (w_bad)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    w_enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d      = ST_RESP;
            w_enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = ST_RESP;
          w_enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (RspReady) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= SIZE_BYTE;
      signed_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_hs) begin
        write_q  <= ReqWrite;
        addr_q   <= ReqAddr;
        wdata_q  <= ReqWData;
        size_q   <= dmr_size_e'(ReqSize);
        signed_q <= ReqSigned;
      end
      if (w_enter_resp) begin
        err_q   <= w_err;
        rdata_q <= (w_err || w_cur_write) ? 32'h0 : w_load;
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge Clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem_q[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
        end
      end
    end
  end

  assign ReqReady = w_idle;
  assign RspValid = (state_q == ST_RESP);
  assign RspRData = rdata_q;
  assign RspError = err_q;

`ifdef DMR_ERR_COUNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      err_cnt_q <= '0;
    end else if (w_enter_resp && w_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign ErrCount = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_data_mem_responder: table-driven scoreboard bench plus
// backpressure and reset-during-wait sequences.
// ------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqWrite = 1'b0;
  logic [31:0] ReqAddr = 32'h0;
  logic [31:0] ReqWData = 32'h0;
  logic [1:0]  ReqSize = 2'b00;
  logic        ReqSigned = 1'b0;
  logic        RspValid;
  logic        RspReady = 1'b1;
  logic [31:0] RspRData;
  logic        RspError;
`ifdef DMR_ERR_COUNT_EN
  logic [15:0] ErrCount;
`endif

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqWrite  (ReqWrite),
    .ReqAddr   (ReqAddr),
    .ReqWData  (ReqWData),
    .ReqSize   (ReqSize),
    .ReqSigned (ReqSigned),
    .RspValid  (RspValid),
    .RspReady  (RspReady),
    .RspRData  (RspRData),
    .RspError  (RspError)
`ifdef DMR_ERR_COUNT_EN
    ,
    .ErrCount  (ErrCount)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    ReqWrite  = v.wr;
    ReqAddr   = v.addr;
    ReqWData  = v.wdata;
    ReqSize   = v.size;
    ReqSigned = v.sgn;
    ReqValid  = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (!ReqReady && t < 100) begin
      @(negedge Clk);
      t++;
    end
    if (!ReqReady) chk({name, " idle timeout"}, 32'(ReqReady), 32'd1);
  endtask

  task automatic pop_compare(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, " unexpected rsp"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, " rdata"}, RspRData, e.rdata);
      chk({name, " err"}, 32'(RspError), 32'(e.err));
    end
  endtask

  // Issue one request at a negedge; returns at the negedge where RspValid is seen.
  task automatic issue(input string name, input vec_t v);
    int lat;
    wait_idle(name);
    drive_req(v);
    sb.push_back('{v.exp_rdata, v.exp_err});
    @(posedge Clk);
    @(negedge Clk);
    ReqValid = 1'b0;
    lat = 1;
    while (!RspValid && lat < 100) begin
      @(negedge Clk);
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(1 + WAITC));
    if (!RspValid) void'(sb.pop_front());
  endtask

  task automatic run_vec(input string name, input vec_t v);
    issue(name, v);
    if (RspValid) pop_compare(name);
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   n_err_exp;

    //            wr    addr          wdata         size   sgn   exp_rdata     err
    tbl.push_back('{1'b1, 32'h0000_0000, 32'h1122_3344, 2'b10, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0011, 32'h0000_0080, 2'b00, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0011, 32'h0,         2'b00, 1'b1, 32'hFFFF_FF80, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0011, 32'h0,         2'b00, 1'b0, 32'h0000_0080, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         2'b10, 1'b0, 32'hDEAD_80EF, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0013, 32'h0,         2'b01, 1'b0, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b1, 32'h0000_1000, 32'h0000_0004, 2'b10, 1'b0, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 32'h0000_0000, 32'h0,         2'b10, 1'b0, 32'h1122_3344, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0012, 32'h0,         2'b01, 1'b1, 32'hFFFF_DEAD, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         2'b01, 1'b0, 32'h0000_80EF, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0011, 32'h0000_FFFF, 2'b01, 1'b0, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         2'b10, 1'b0, 32'hDEAD_80EF, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0012, 32'hABCD_1234, 2'b01, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         2'b10, 1'b0, 32'h1234_80EF, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0012, 32'h0,         2'b10, 1'b0, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         2'b11, 1'b0, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         2'b00, 1'b1, 32'hFFFF_FFEF, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0FFC, 32'h0,         2'b10, 1'b0, 32'hCAFE_F00D, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0020, 32'h0BAD_F00D, 2'b10, 1'b0, 32'h0000_0000, 1'b0});

    // Reset state
    @(negedge Clk);
    @(negedge Clk);
    chk("reset ReqReady", 32'(ReqReady), 32'd1);
    chk("reset RspValid", 32'(RspValid), 32'd0);
    chk("reset RspRData", RspRData, 32'h0);
    chk("reset RspError", 32'(RspError), 32'd0);
`ifdef DMR_ERR_COUNT_EN
    chk("reset ErrCount", 32'(ErrCount), 32'd0);
`endif
    Reset = 1'b1;
    @(negedge Clk);

    n_err_exp = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
      if (tbl[i].exp_err) n_err_exp++;
    end
`ifdef DMR_ERR_COUNT_EN
    chk("ErrCount after table", 32'(ErrCount), 32'(n_err_exp));
`endif

    // Backpressure: response held, second request ignored
    RspReady = 1'b0;
    issue("bp", '{1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h1234_80EF, 1'b0});
    for (int c = 0; c < 5; c++) begin
      drive_req('{1'b1, 32'h10, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0});
      chk($sformatf("bp hold%0d RspValid", c), 32'(RspValid), 32'd1);
      chk($sformatf("bp hold%0d RspRData", c), RspRData, 32'h1234_80EF);
      chk($sformatf("bp hold%0d ReqReady", c), 32'(ReqReady), 32'd0);
      @(negedge Clk);
    end
    ReqValid = 1'b0;
    pop_compare("bp release");
    RspReady = 1'b1;
    @(negedge Clk);
    chk("bp after ack RspValid", 32'(RspValid), 32'd0);
    chk("bp after ack ReqReady", 32'(ReqReady), 32'd1);
    run_vec("bp ignored store", '{1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h1234_80EF, 1'b0});

    // Reset asserted while a store is waiting
    wait_idle("rst");
    drive_req('{1'b1, 32'h20, 32'h0000_0055, 2'b10, 1'b0, 32'h0, 1'b0});
    @(posedge Clk);
    @(negedge Clk);
    ReqValid = 1'b0;
    chk("rst in WAIT ReqReady", 32'(ReqReady), 32'd0);
    Reset = 1'b0;
    #1;
    chk("rst async ReqReady", 32'(ReqReady), 32'd1);
    chk("rst async RspValid", 32'(RspValid), 32'd0);
`ifdef DMR_ERR_COUNT_EN
    chk("rst ErrCount", 32'(ErrCount), 32'd0);
`endif
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("post rst RspValid", 32'(RspValid), 32'd0);
    run_vec("rst store dropped", '{1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h0BAD_F00D, 1'b0});

    // Three misaligned requests
    run_vec("mis0", '{1'b0, 32'h1, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1});
    run_vec("mis1", '{1'b0, 32'h2, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1});
    run_vec("mis2", '{1'b1, 32'h3, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0, 1'b1});
`ifdef DMR_ERR_COUNT_EN
    chk("ErrCount three", 32'(ErrCount), 32'd3);
`endif
    run_vec("mis store suppressed", '{1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'h1122_3344, 1'b0});

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra access cycles inserted before response (0..15).
REQ-003 SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 Port Clk  in  1  clock; all state changes on rising edge.
REQ-005 Port Reset  in  1  asynchronous, active-low reset.
REQ-006 Port ReqValid  in  1  request present from the pipeline memory stage.
REQ-007 Port ReqReady  out  1  responder can accept a request.
REQ-008 Port ReqWrite  in  1  1 = store, 0 = load.
REQ-009 Port ReqAddr  in  32  byte address.
REQ-010 Port ReqWData  in  32  store data, right-aligned.
REQ-011 Port ReqSize  in  2  00 byte, 01 half, 10 word; 11 reserved.
REQ-012 Port ReqSigned  in  1  load sign-extends when 1, zero-extends when 0.
REQ-013 Port RspValid  out  1  response present.
REQ-014 Port RspReady  in  1  pipeline accepts response.
REQ-015 Port RspRData  out  32  load data, extended; 0 for stores and errors.
REQ-016 Port RspError  out  1  request was misaligned, out of range or reserved size.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; ReqReady = 1 only in IDLE.
REQ-018 Handshake fires when ReqValid && ReqReady; SHALL latch write, address, data, size and signed on that edge.
REQ-019 From IDLE on handshake: to WAIT with counter = WAIT_CYCLES-1 if WAIT_CYCLES > 0, else to RESP.
REQ-020 WAIT SHALL decrement each cycle and go to RESP on the cycle it reads 0.
REQ-021 Memory access (read sample or write commit) SHALL occur on the edge entering RESP; latency handshake-to-RspValid = 1 + WAIT_CYCLES cycles.
REQ-022 RESP: RspValid = 1; RspRData/RspError SHALL be held stable until RspValid && RspReady, then IDLE.
REQ-023 At most one outstanding request; ReqValid in WAIT/RESP SHALL be ignored.
REQ-024 Byte lanes little-endian: byte lane = addr[1:0], half lane = addr[1]; stores write only addressed lanes.
REQ-025 Error if half with addr[0]=1, word with addr[1:0]!=0, size 11, or addr[31:2] >= DEPTH_WORDS; error SHALL suppress write and force RspRData = 0.
REQ-026 Word index SHALL be addr[31:2]; no wrap-around on out-of-range addresses.

Reset
REQ-027 Reset low SHALL force IDLE, counter 0, RspValid 0, RspRData 0, RspError 0, ReqReady 1.
REQ-028 Reset mid-operation SHALL drop the pending request; an uncommitted store SHALL NOT write.
REQ-029 Memory array SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro DMR_ERR_COUNT_EN: when defined, output ErrCount (out, 16) counts handshakes resulting in RspError, saturating at 16'hFFFF, reset to 0.
REQ-031 Without DMR_ERR_COUNT_EN, port ErrCount and its counter SHALL not exist; all other behaviour identical.

Structure
REQ-032 Shared package dmr_pkg SHALL hold ReqSize encodings, FSM state encoding and WAIT counter width.
REQ-033 One sub-module dmr_lane_align (combinational): write byte-mask/data shifting and load extraction/extension.

Verification
REQ-034 WAIT_CYCLES=2: store word 0xDEADBEEF to 0x10, load word 0x10 -> RspValid 3 cycles after each handshake, RspRData 0xDEADBEEF, RspError 0.
REQ-035 Store byte 0x80 to 0x11, then load byte signed 0x11 -> 0xFFFFFF80; unsigned -> 0x00000080; word 0x10 -> 0xDEAD80EF.
REQ-036 Load half at 0x13 -> RspError 1, RspRData 0; store word 0x4 to 0x1000 with DEPTH_WORDS=1024 -> RspError 1, memory unchanged.
REQ-037 Hold RspReady 0 for 5 cycles in RESP -> RspValid/RspRData stable, ReqReady 0, second ReqValid ignored.
REQ-038 Assert Reset low during WAIT of store 0x55 to 0x20 -> IDLE next, later load of 0x20 returns prior value.
REQ-039 With DMR_ERR_COUNT_EN, 3 misaligned requests -> ErrCount 3; reset -> 0.
